// File: rtl/scan_cycle_controller_if.sv
// ============================================================================
// Module  : scan_cycle_controller_if
// Brief   : Control, image and status signals of the scan-cycle controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface scan_cycle_controller_if #(
    parameter int INPUTS  = 8,
    parameter int OUTPUTS = 8
);
    logic               start;
    logic               endOfScan;
    logic               faultClear;
    logic [INPUTS-1:0]  IN;
    logic [OUTPUTS-1:0] outImage;
    logic [INPUTS-1:0]  inSnap;
    logic [OUTPUTS-1:0] OUT;
    logic               cpuReset;
    logic               cpuRun;
    logic [2:0]         phase;
    logic [15:0]        scanCount;
    logic               wdtFault;

    modport master (
        output start, endOfScan, faultClear, IN, outImage,
        input  inSnap, OUT, cpuReset, cpuRun, phase, scanCount, wdtFault
    );

    modport slave (
        input  start, endOfScan, faultClear, IN, outImage,
        output inSnap, OUT, cpuReset, cpuRun, phase, scanCount, wdtFault
    );
endinterface

`default_nettype wire

// File: rtl/scan_cycle_controller.sv
// ============================================================================
// Module  : scan_cycle_controller
// Brief   : PLC-style scan sequencer: input snapshot, execute with watchdog,
//           pipeline drain, output update; sticky fault on watchdog expiry.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_cycle_controller #(
    parameter int INPUTS       = 8,
    parameter int OUTPUTS      = 8,
    parameter int WDT_LIMIT    = 1024,
    parameter int DRAIN_CYCLES = 3
) (
    input  wire logic              clk,
    input  wire logic              reset,
    scan_cycle_controller_if.slave bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INSCAN  = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_OUTSCAN = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;

    localparam logic [15:0] c_WDT_LAST   = 16'(WDT_LIMIT - 1);
    localparam logic [3:0]  c_DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [15:0]        r_wdt_cnt;
    logic [3:0]         r_drain_cnt;
    logic [INPUTS-1:0]  r_in_snap;
    logic [OUTPUTS-1:0] r_out;
    logic [15:0]        r_scan_count;
    logic               r_wdt_fault;
    logic               w_fault_entry;
    logic               w_fault_exit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // endOfScan is only looked at in EXEC, and it outranks watchdog expiry.
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE:    w_next_state = bus.start ? S_INSCAN : S_IDLE;
            S_INSCAN:  w_next_state = S_EXEC;
            S_EXEC: begin
                if (bus.endOfScan)             w_next_state = S_DRAIN;
                else if (r_wdt_cnt == c_WDT_LAST) w_next_state = S_FAULT;
                else                           w_next_state = S_EXEC;
            end
            S_DRAIN:   w_next_state = (r_drain_cnt == 4'd0) ? S_OUTSCAN : S_DRAIN;
            S_OUTSCAN: w_next_state = bus.start ? S_INSCAN : S_IDLE;
            S_FAULT:   w_next_state = (bus.faultClear && !bus.start) ? S_IDLE : S_FAULT;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cpuRun   = 1'b0;
        bus.cpuReset = 1'b1;
        bus.phase    = r_state;
        if (r_state == S_EXEC || r_state == S_DRAIN) begin
            bus.cpuRun   = 1'b1;
            bus.cpuReset = 1'b0;
        end
    end

    assign w_fault_entry = (r_state == S_EXEC)  && (w_next_state == S_FAULT);
    assign w_fault_exit  = (r_state == S_FAULT) && (w_next_state == S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdt_cnt    <= 16'd0;
            r_drain_cnt  <= 4'd0;
            r_in_snap    <= '0;
            r_out        <= '0;
            r_scan_count <= 16'd0;
            r_wdt_fault  <= 1'b0;
        end else begin
            // Watchdog is zero in the first EXEC cycle, so EXEC lasts at most WDT_LIMIT cycles.
            r_wdt_cnt <= (r_state == S_EXEC) ? r_wdt_cnt + 16'd1 : 16'd0;

            if (r_state != S_DRAIN && w_next_state == S_DRAIN) begin
                r_drain_cnt <= c_DRAIN_LOAD;
            end else if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt - 4'd1;
            end

            if (r_state == S_INSCAN) begin
                r_in_snap <= bus.IN;
            end

            if (r_state == S_OUTSCAN) begin
                r_out        <= bus.outImage;
                r_scan_count <= r_scan_count + 16'd1;
            end else if (w_fault_entry) begin
                r_out <= '0;
            end

            if (w_fault_entry) begin
                r_wdt_fault <= 1'b1;
            end else if (w_fault_exit) begin
                r_wdt_fault <= 1'b0;
            end
        end
    end

    assign bus.inSnap    = r_in_snap;
    assign bus.OUT       = r_out;
    assign bus.scanCount = r_scan_count;
    assign bus.wdtFault  = r_wdt_fault;

endmodule

`default_nettype wire

// File: doc/scan_cycle_controller.md
SCAN_CYCLE_CONTROLLER -- requirements
Module: scan_cycle_controller

Interface
REQ-001 Parameter INPUTS, default 8: width of the physical input image.
REQ-002 Parameter OUTPUTS, default 8: width of the physical output image.
REQ-003 Parameter WDT_LIMIT, default 1024: maximum EXEC cycles per scan; legal range 2..65535.
REQ-004 Parameter DRAIN_CYCLES, default 3: post-END pipeline drain cycles; legal range 1..15.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  level; 1 = run continuous scans, 0 = stop after the current scan.
REQ-008 endOfScan  in  1  one-cycle pulse from the control unit when the END instruction is decoded.
REQ-009 faultClear  in  1  level; acknowledges a watchdog fault.
REQ-010 IN  in  INPUTS  raw physical inputs.
REQ-011 outImage  in  OUTPUTS  output image from the output register.
REQ-012 inSnap  out  INPUTS  frozen input image presented to the input register.
REQ-013 OUT  out  OUTPUTS  physical outputs.
REQ-014 cpuReset  out  1  holds the program counter and pipeline at reset.
REQ-015 cpuRun  out  1  processor executing.
REQ-016 phase  out  3  current state encoding.
REQ-017 scanCount  out  16  count of completed scans.
REQ-018 wdtFault  out  1  sticky watchdog fault flag.

Function
REQ-019 FSM states and phase codes SHALL be: IDLE=0, INSCAN=1, EXEC=2, DRAIN=3, OUTSCAN=4, FAULT=5; codes 6-7 SHALL recover to IDLE.
REQ-020 IDLE: cpuReset=1, cpuRun=0; if start=1 then go to INSCAN on the next edge.
REQ-021 INSCAN: lasts one cycle; cpuReset=1; inSnap<=IN on the edge leaving the state; next state is EXEC.
REQ-022 EXEC: cpuReset=0, cpuRun=1; the watchdog counter (16-bit) clears on entry and increments each EXEC cycle.
REQ-023 EXEC with endOfScan=1: go to DRAIN.
REQ-024 EXEC with counter==WDT_LIMIT-1 and endOfScan=0: go to FAULT and set wdtFault=1; EXEC therefore lasts at most WDT_LIMIT cycles.
REQ-025 When endOfScan and watchdog expiry occur in the same cycle, endOfScan SHALL win with no fault.
REQ-026 DRAIN: cpuReset=0, cpuRun=1; a 4-bit down-counter loads DRAIN_CYCLES-1 on entry; at 0 go to OUTSCAN; DRAIN lasts exactly DRAIN_CYCLES cycles.
REQ-027 OUTSCAN: lasts one cycle; cpuRun=0, cpuReset=1.
REQ-028 OUTSCAN: on the leaving edge, OUT<=outImage and scanCount<=scanCount+1, wrapping 0xFFFF->0x0000.
REQ-029 OUTSCAN next state: INSCAN if start=1, else IDLE.
REQ-030 FAULT: cpuReset=1, cpuRun=0, OUT forced to all-zero on entry and held at zero.
REQ-031 FAULT: go to IDLE only when faultClear=1 and start=0; wdtFault clears on that edge.
REQ-032 endOfScan SHALL be ignored outside EXEC.
REQ-033 start falling mid-scan SHALL NOT abort the scan; the scan completes through OUTSCAN, then goes to IDLE.
REQ-034 inSnap SHALL be stable for the entire EXEC/DRAIN window of a scan.
REQ-035 OUT SHALL change only at the OUTSCAN exit edge or on FAULT entry.
REQ-036 Min scan length: 1 (INSCAN) + 1 (EXEC) + DRAIN_CYCLES + 1 (OUTSCAN).

Reset
REQ-037 Asserting reset SHALL force immediately, at any state: state=IDLE, phase=0, inSnap=0, OUT=0, scanCount=0, wdtFault=0, both counters=0, cpuReset=1, cpuRun=0.
REQ-038 A reset mid-EXEC SHALL discard the scan with no OUT update and no scanCount increment.
REQ-039 After reset release with start=1, INSCAN SHALL be entered on the first clock edge.

Verification
REQ-040 Normal scan: start=1, IN=0xA5, endOfScan on the 5th EXEC cycle, outImage=0x3C -> inSnap=0xA5; phase sequence 1,2x5,3x3,4,1; OUT=0x3C; scanCount=1.
REQ-041 Watchdog: WDT_LIMIT=16, no endOfScan -> after 16 EXEC cycles phase=5, wdtFault=1, OUT=0x00, cpuReset=1; faultClear=1 with start=1 -> stays in FAULT; with start=0 -> phase=0, wdtFault=0.
REQ-042 Tie: WDT_LIMIT=16, endOfScan on the 16th EXEC cycle -> DRAIN entered, wdtFault=0.
REQ-043 Stop and IN stability: start dropped in EXEC -> scan completes, then phase=0 with OUT updated; IN toggled during EXEC -> inSnap unchanged.
REQ-044 Wrap and reset: preload 0xFFFF scans -> scanCount=0x0000; reset pulsed in DRAIN -> all outputs at reset values within the same cycle, with no OUT update.
